// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack with combinational top-of-stack and sticky error flags
//
// Purpose: DEPTH x WIDTH LIFO serving the stack-machine datapath. It is the
// responder end of the push/pop/tos command interface. The top entry is
// presented combinationally, so a pop can capture d_out in the same cycle.
//
// Optional feature macro: STACK_PEEK_EN (adds peek_idx / peek_data).
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (sp and error flags only)
//   push      in   write d_in as new top
//   pop       in   remove top entry (push+pop together = replace top)
//   tos       in   top-of-stack read strobe, only flags underflow when empty
//   d_in      in   [WIDTH-1:0] data to push
//   err_clr   in   clear sticky error flags
//   d_out     out  [WIDTH-1:0] current top entry, zero when empty
//   count     out  [CW-1:0] number of valid entries
//   empty     out  count == 0
//   full      out  count == DEPTH
//   ovf_err   out  sticky: push attempted while full
//   udf_err   out  sticky: pop or tos attempted while empty
//   peek_idx  in   [$clog2(DEPTH)-1:0] depth below top (STACK_PEEK_EN only)
//   peek_data out  [WIDTH-1:0] entry at that depth, zero if invalid (STACK_PEEK_EN only)
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] d_in,
  input  logic             err_clr,
`ifdef STACK_PEEK_EN
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             udf_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, udf_q;
  logic             ovf_set, udf_set;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             is_empty, is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));
  // Only meaningful when the stack is non-empty / not full respectively.
  assign top_idx  = AW'(sp_q - CW'(1));
  assign push_idx = AW'(sp_q);

  always_comb begin
    sp_d    = sp_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = push_idx;
    if (push && pop) begin
      if (is_empty) begin
        // Nothing to replace: behaves as a plain push but still flags underflow.
        wr_en   = 1'b1;
        wr_idx  = '0;
        sp_d    = CW'(1);
        udf_set = 1'b1;
      end else begin
        // Replace-top never changes occupancy, so it is legal even when full.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
    end else if (push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        udf_set = 1'b1;
      end else begin
        sp_d = sp_q - CW'(1);
      end
    end
    if (tos && is_empty) begin
      udf_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      // A new error in the same cycle as err_clr wins.
      ovf_q <= ovf_set | (ovf_q & ~err_clr);
      udf_q <= udf_set | (udf_q & ~err_clr);
    end
  end

  // Storage has no reset; entries at or above sp are never observable.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_idx] <= d_in;
    end
  end

  assign d_out   = is_empty ? '0 : mem[top_idx];
  assign count   = sp_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

`ifdef STACK_PEEK_EN
  logic [CW-1:0] peek_ext;
  assign peek_ext  = CW'(peek_idx);
  assign peek_data = (peek_ext < sp_q) ? mem[AW'(sp_q - CW'(1) - peek_ext)] : '0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - table-driven self-checking bench for stack_unit
module tb_stack_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst, push, pop, tos, err_clr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;
  logic             empty, full, ovf_err, udf_err;
`ifdef STACK_PEEK_EN
  logic [AW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
    .d_in(d_in), .err_clr(err_clr),
`ifdef STACK_PEEK_EN
    .peek_idx(peek_idx), .peek_data(peek_data),
`endif
    .d_out(d_out), .count(count), .empty(empty), .full(full),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  typedef struct {
    logic       rst, push, pop, tos, err_clr;
    logic [7:0] d_in;
    logic [7:0] e_dout;
    int         e_count;
    logic       e_ovf, e_udf;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic r, input logic pu, input logic po, input logic t,
                     input logic ec, input logic [7:0] din, input logic [7:0] edo,
                     input int ecnt, input logic eo, input logic eu);
    vecs[nv].rst = r;  vecs[nv].push = pu; vecs[nv].pop = po;
    vecs[nv].tos = t;  vecs[nv].err_clr = ec; vecs[nv].d_in = din;
    vecs[nv].e_dout = edo; vecs[nv].e_count = ecnt;
    vecs[nv].e_ovf = eo; vecs[nv].e_udf = eu;
    nv++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pu, input logic po, input logic t,
                       input logic ec, input logic [7:0] din);
    @(negedge clk);
    rst = r; push = pu; pop = po; tos = t; err_clr = ec; d_in = din;
  endtask

  task automatic check_state(input string tag, input logic [7:0] edo, input int ecnt,
                             input logic eo, input logic eu);
    chk({tag, " d_out"}, int'(d_out), int'(edo));
    chk({tag, " count"}, int'(count), ecnt);
    chk({tag, " empty"}, int'(empty), int'(ecnt == 0));
    chk({tag, " full"},  int'(full),  int'(ecnt == DEPTH));
    chk({tag, " ovf"},   int'(ovf_err), int'(eo));
    chk({tag, " udf"},   int'(udf_err), int'(eu));
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0; d_in = '0;
`ifdef STACK_PEEK_EN
    peek_idx = '0;
`endif

    //   rst pu po tos clr din    d_out cnt ovf udf
    add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h11,  8'h11, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'h22,  8'h22, 2, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00,  8'h11, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00,  8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00,  8'h00, 0, 0, 1);  // pop while empty
    add(0, 0, 0, 1, 0, 8'h00,  8'h00, 0, 0, 1);  // tos while empty, flag held
    add(0, 0, 0, 0, 1, 8'h00,  8'h00, 0, 0, 0);  // err_clr alone
    add(0, 0, 1, 0, 1, 8'h00,  8'h00, 0, 0, 1);  // new error beats clear
    add(0, 0, 0, 0, 1, 8'h00,  8'h00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00,  8'h00, 0, 0, 1);  // tos alone while empty
    add(0, 0, 0, 0, 1, 8'h00,  8'h00, 0, 0, 0);
    add(0, 1, 1, 0, 0, 8'h33,  8'h33, 1, 0, 1);  // push+pop on empty acts as push
    add(0, 0, 0, 0, 1, 8'h00,  8'h33, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'h44,  8'h44, 2, 0, 0);
    add(0, 1, 0, 0, 0, 8'h05,  8'h05, 3, 0, 0);
    add(0, 1, 1, 0, 0, 8'h09,  8'h09, 3, 0, 0);  // replace-top
    add(0, 0, 0, 1, 0, 8'h00,  8'h09, 3, 0, 0);  // tos non-empty: no effect
    add(0, 0, 1, 0, 0, 8'h00,  8'h44, 2, 0, 0);  // entry below replaced top intact
    add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++)
      add(0, 1, 0, 0, 0, 8'(i), 8'(i), i, 0, 0);
    add(0, 1, 0, 0, 0, 8'hAA,  8'h08, 8, 1, 0);  // push while full
    add(0, 0, 0, 0, 1, 8'h00,  8'h08, 8, 0, 0);
    add(0, 1, 1, 0, 0, 8'h09,  8'h09, 8, 0, 0);  // replace-top while full
    add(0, 1, 1, 0, 0, 8'h0C,  8'h0C, 8, 0, 0);
    add(0, 1, 0, 0, 1, 8'hAA,  8'h0C, 8, 1, 0);  // overflow beats clear
    add(0, 0, 1, 0, 0, 8'h00,  8'h07, 7, 1, 0);
    add(0, 1, 0, 0, 0, 8'hBB,  8'hBB, 8, 1, 0);
    add(1, 1, 1, 0, 0, 8'h55,  8'h00, 0, 0, 0);  // rst overrides commands
    add(0, 0, 1, 0, 0, 8'h00,  8'h00, 0, 0, 1);
    add(0, 1, 0, 0, 0, 8'h66,  8'h66, 1, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00,  8'h66, 1, 0, 0);

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].err_clr, vecs[i].d_in);
      @(posedge clk); #1;
      check_state($sformatf("v%0d", i), vecs[i].e_dout, vecs[i].e_count,
                  vecs[i].e_ovf, vecs[i].e_udf);
    end

    // ALU sequence: d_out must show the popped value during the pop cycle.
    drive(1, 0, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 0, 8'd3);
    drive(0, 1, 0, 0, 0, 8'd4);
    drive(0, 0, 1, 0, 0, 8'h00);
    #1 chk("alu pop1 same-cycle d_out", int'(d_out), 4);
    drive(0, 0, 1, 0, 0, 8'h00);
    #1 chk("alu pop2 same-cycle d_out", int'(d_out), 3);
    chk("alu pop2 count before edge", int'(count), 1);
    drive(0, 1, 0, 0, 0, 8'd7);
    #1 chk("alu after pops count", int'(count), 0);
    @(posedge clk); #1;
    check_state("alu push7", 8'd7, 1, 0, 0);

    // Reset mid-operation after five pushes, reset coinciding with a push.
    drive(1, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 5; i++) drive(0, 1, 0, 0, 0, 8'(i * 16));
    drive(0, 0, 0, 0, 0, 8'h00);
    #1 chk("mid count", int'(count), 5);
    chk("mid d_out", int'(d_out), 8'h50);
`ifdef STACK_PEEK_EN
    peek_idx = AW'(0); #1 chk("peek0", int'(peek_data), 8'h50);
    peek_idx = AW'(2); #1 chk("peek2", int'(peek_data), 8'h30);
    peek_idx = AW'(4); #1 chk("peek4", int'(peek_data), 8'h10);
    peek_idx = AW'(5); #1 chk("peek5", int'(peek_data), 8'h00);
`endif
    drive(1, 1, 0, 0, 0, 8'h77);
    @(posedge clk); #1;
    check_state("mid rst", 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
